// File: rtl/rom_arb_pkg.sv
// Shared definitions for the ROM read-port arbiter and its round-robin core.
package rom_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  // Ceiling log2, never less than 1 so a two-requester build still gets an ID bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request bit searching upward
// from last_grant+1, wrapping modulo NUM_REQ.
module rr_arbiter
  import rom_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_BITS = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_BITS-1:0] last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_BITS-1:0] grant_idx,
  output logic               any_req
);

  logic [ID_BITS-1:0] cand;

  // Rotating priority scan; the first hit wins and later hits are ignored.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_req   = 1'b0;
    cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = ID_BITS'((int'(last_grant) + i) % NUM_REQ);
      if (!any_req && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        any_req     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rom_read_arbiter.sv
// Shares one ROM read port among NUM_REQ requesters; responses return on a
// single tagged channel with backpressure.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for a request; grant, address and read_en driven here
// READ    | ROM word valid on rom_read_data (sync or async ROM), captured
// RESP    | response held on resp_* until resp_ready
module rom_read_arbiter
  import rom_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_BITS  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_BITS    = clog2(NUM_REQ)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*ADDR_BITS-1:0]   req_addr,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic [ID_BITS-1:0]             resp_id,
  output logic [DATA_WIDTH-1:0]          resp_data,
  output logic                           rom_read_clk,
  output logic                           rom_read_en,
  output logic [ADDR_BITS-1:0]           rom_read_addr,
  input  logic [DATA_WIDTH-1:0]          rom_read_data
);

  arb_state_t               state;
  arb_state_t               state_nxt;
  logic [ADDR_BITS-1:0]     addr_reg;
  logic [ID_BITS-1:0]       id_reg;
  logic [ID_BITS-1:0]       last_grant;
  logic [ADDR_BITS-1:0]     addr_arr [NUM_REQ];
  logic [NUM_REQ-1:0]       grant;
  logic [ID_BITS-1:0]       grant_idx;
  logic                     any_req;

  // The ROM is clocked directly from the arbiter clock so sync-read timing lines up.
  assign rom_read_clk = clock;

  // Unpack the flat address bus into one slice per requester.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_arr[i] = req_addr[i*ADDR_BITS +: ADDR_BITS];
    end
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_BITS (ID_BITS)
  ) u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .any_req    (any_req)
  );

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and port-side outputs; the address only moves in IDLE so a
  // sync-read ROM latches it at the grant edge and it stays quiet afterwards.
  always_comb begin
    state_nxt     = state;
    req_ready     = '0;
    rom_read_en   = 1'b0;
    rom_read_addr = addr_reg;
    case (state)
      ST_IDLE: begin
        if (any_req) begin
          req_ready     = grant;
          rom_read_en   = 1'b1;
          rom_read_addr = addr_arr[grant_idx];
          state_nxt     = ST_READ;
        end
      end
      ST_READ: begin
        state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Transaction datapath: latch the winner at grant, sample the ROM once in
  // READ so later ROM changes cannot disturb a pending response.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_reg   <= '0;
      id_reg     <= '0;
      last_grant <= ID_BITS'(NUM_REQ - 1);
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_data  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            addr_reg   <= addr_arr[grant_idx];
            id_reg     <= grant_idx;
            last_grant <= grant_idx;
          end
        end
        ST_READ: begin
          resp_data  <= rom_read_data;
          resp_id    <= id_reg;
          resp_valid <= 1'b1;
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
